// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter in front of a single-port data memory
module dmem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_b_q, last_b_d, sel_b_q, sel_b_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d, mem_raddr_q, mem_raddr_d, mem_waddr_q, mem_waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d, a_done_q, a_done_d, b_done_q, b_done_d;
    logic              a_err_q, a_err_d, b_err_q, b_err_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic              pick_b, nxt_we, nxt_oor, oor;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] nxt_wdata, rd;

    // B wins alone, or on a tie when A was granted last
    assign pick_b    = b_req && (!a_req || !last_b_q);
    assign nxt_we    = pick_b ? b_we : a_we;
    assign nxt_addr  = pick_b ? b_addr : a_addr;
    assign nxt_wdata = pick_b ? b_wdata : a_wdata;
    assign nxt_oor   = nxt_addr >= ADDR_W'(DEPTH);
    assign oor       = addr_q >= ADDR_W'(DEPTH);
    assign rd        = oor ? '0 : mem_rdata;

    always_comb begin
        state_d     = state_q;
        last_b_d    = last_b_q;
        sel_b_d     = sel_b_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        mem_raddr_d = mem_raddr_q;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        a_gnt_d     = 1'b0;
        b_gnt_d     = 1'b0;
        a_done_d    = 1'b0;
        b_done_d    = 1'b0;
        a_err_d     = 1'b0;
        b_err_d     = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        case (state_q)
            IDLE: if (a_req || b_req) begin
                state_d     = ACCESS;
                sel_b_d     = pick_b;
                last_b_d    = pick_b;
                we_d        = nxt_we;
                addr_d      = nxt_addr;
                wdata_d     = nxt_wdata;
                a_gnt_d     = !pick_b;
                b_gnt_d     = pick_b;
                mem_read_d  = !nxt_we && !nxt_oor;
                mem_write_d = nxt_we && !nxt_oor;
                mem_raddr_d = mem_read_d ? nxt_addr : mem_raddr_q;
                mem_waddr_d = mem_write_d ? nxt_addr : mem_waddr_q;
                mem_wdata_d = mem_write_d ? nxt_wdata : mem_wdata_q;
            end
            ACCESS: begin
                state_d   = RESP;
                a_done_d  = !sel_b_q;
                b_done_d  = sel_b_q;
                a_err_d   = !sel_b_q && oor;
                b_err_d   = sel_b_q && oor;
                a_rdata_d = (!we_q && !sel_b_q) ? rd : a_rdata_q;
                b_rdata_d = (!we_q && sel_b_q) ? rd : b_rdata_q;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_b_q    <= 1'b1;
            sel_b_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            mem_raddr_q <= '0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            a_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
            a_err_q     <= 1'b0;
            b_err_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_b_q    <= last_b_d;
            sel_b_q     <= sel_b_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            mem_raddr_q <= mem_raddr_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            a_gnt_q     <= a_gnt_d;
            b_gnt_q     <= b_gnt_d;
            a_done_q    <= a_done_d;
            b_done_q    <= b_done_d;
            a_err_q     <= a_err_d;
            b_err_q     <= b_err_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign a_gnt     = a_gnt_q;
    assign b_gnt     = b_gnt_q;
    assign a_done    = a_done_q;
    assign b_done    = b_done_q;
    assign a_err     = a_err_q;
    assign b_err     = b_err_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_raddr = mem_raddr_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of arbitration, latency, range errors and reset
module tb_dmem_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, a_done, a_err, b_gnt, b_done, b_err, mem_read, mem_write;
    logic [DW-1:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic [DW-1:0] mem [0:DEPTH-1];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata), .b_err(b_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_raddr(mem_raddr),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // memory holds i+0x100 after reset
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 64'(i) + 64'h100;
        end else if (mem_write) begin
            mem[mem_waddr[6:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_read ? mem[mem_raddr[6:0]] : '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic pb, input logic we, input logic [63:0] addr, input logic [63:0] wd);
        if (pb) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end
        step();
        a_req = 1'b0; b_req = 1'b0;
        a_addr = 64'h9; a_wdata = '0; b_addr = 64'h9; b_wdata = '0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("rd_wr_excl", {63'd0, mem_read & mem_write}, 64'd0);
            check("gnt_excl", {63'd0, a_gnt & b_gnt}, 64'd0);
        end
    end

    initial begin
        step(); step();
        a_req = 1'b1; b_req = 1'b1;
        step();
        check("rst_a_gnt", a_gnt, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_done", {a_done, b_done, a_err, b_err}, 0);
        check("rst_strobes", {mem_read, mem_write}, 0);
        check("rst_addr", mem_raddr | mem_waddr, 0);
        check("rst_data", a_rdata | b_rdata | mem_wdata, 0);
        rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
        step();

        issue(0, 1, 3, 64'h55);
        check("wr_gnt", {a_gnt, b_gnt}, 2'b10);
        check("wr_strobe", {mem_read, mem_write}, 2'b01);
        check("wr_waddr", mem_waddr, 3);
        check("wr_wdata", mem_wdata, 64'h55);
        step();
        check("wr_done", {a_done, a_err, mem_write}, 3'b100);
        step();
        check("wr_idle", a_done, 0);

        issue(0, 0, 3, 0);
        check("rd_gnt", a_gnt, 1);
        check("rd_strobe", {mem_read, mem_write}, 2'b10);
        check("rd_raddr", mem_raddr, 3);
        step();
        check("rd_done", {a_done, a_err, b_done}, 3'b100);
        check("rd_data", a_rdata, 64'h55);
        step();

        issue(0, 0, 1, 0);
        step();
        check("hold_pre", a_rdata, 64'h101);
        step();
        issue(1, 1, 1, 64'h99);
        check("bw_gnt", {a_gnt, b_gnt}, 2'b01);
        check("bw_waddr", mem_waddr, 1);
        step();
        check("bw_done", {b_done, a_done}, 2'b10);
        check("hold_a", a_rdata, 64'h101);
        check("bw_b_rdata", b_rdata, 0);
        step();
        issue(1, 0, 1, 0);
        step();
        check("br_data", b_rdata, 64'h99);
        check("hold_a2", a_rdata, 64'h101);
        step();

        issue(1, 0, 200, 0);
        check("oor_gnt", b_gnt, 1);
        check("oor_no_rd", mem_read, 0);
        step();
        check("oor_resp", {b_done, b_err, a_err}, 3'b110);
        check("oor_rdata", b_rdata, 0);
        step();
        issue(1, 0, 128, 0);
        check("edge128_no_rd", mem_read, 0);
        step();
        check("edge128_err", b_err, 1);
        step();
        issue(1, 0, 127, 0);
        check("edge127_rd", mem_read, 1);
        step();
        check("edge127_resp", {b_done, b_err}, 2'b10);
        check("edge127_data", b_rdata, 64'h17f);
        step();
        issue(0, 0, 64'h8000_0000_0000_0001, 0);
        check("hi_no_rd", mem_read, 0);
        step();
        check("hi_err", {a_done, a_err}, 2'b11);
        check("hi_rdata", a_rdata, 0);
        step();

        b_req = 1'b1; b_we = 1'b0; b_addr = 2;
        for (int i = 1; i <= 9; i++) begin
            step();
            check($sformatf("solo_b_gnt%0d", i), b_gnt, (i % 3 == 1));
            check($sformatf("solo_a_gnt%0d", i), a_gnt, 0);
        end
        b_req = 1'b0;
        step();

        rst = 1'b1;
        step();
        rst = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 4;
        b_req = 1'b1; b_we = 1'b0; b_addr = 5;
        for (int i = 1; i <= 12; i++) begin
            step();
            check($sformatf("tie_a%0d", i), a_gnt, (i % 6 == 1));
            check($sformatf("tie_b%0d", i), b_gnt, (i % 6 == 4));
        end
        a_req = 1'b0; b_req = 1'b0;
        step(); step(); step();

        issue(0, 1, 5, 64'h77);
        check("ra_gnt", a_gnt, 1);
        rst = 1'b1;
        step();
        check("ra_no_done", {a_done, b_done, a_err, b_err}, 0);
        check("ra_no_strobe", {mem_read, mem_write, a_gnt, b_gnt}, 0);
        check("ra_zero", mem_waddr | mem_wdata | a_rdata | b_rdata, 0);
        rst = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 6;
        b_req = 1'b1; b_we = 1'b0; b_addr = 7;
        step();
        check("ra_tie", {a_gnt, b_gnt}, 2'b10);
        a_req = 1'b0; b_req = 1'b0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
